// File: rtl/mdu.sv
// Multiply/divide unit with architectural HI/LO. MULT/DIV commit after MULT_CYCLES/DIV_CYCLES busy cycles; MTHI/MTLO land next cycle.
// No backpressure: Start is ignored entirely while Busy, so the controller must stall on Start|Busy.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = ($clog2(MAXC + 1) < 4) ? 4 : $clog2(MAXC + 1);
  localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0]   phi, phi_n, plo, plo_n;
  logic          pvalid, pvalid_n;
  logic [31:0]   hi_q, hi_n, lo_q, lo_n;

  logic signed [63:0] smul;
  logic        [63:0] umul;
  assign smul = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign umul = {32'd0, A} * {32'd0, B};

  // One unsigned divider serves both DIV and DIVU; signed results are rebuilt from magnitudes.
  logic        div_signed, a_neg, b_neg, b_zero;
  logic [31:0] a_mag, b_mag, dvsr, uquo, urem, quo, rem;
  assign div_signed = ~MDUOp[0];
  assign a_neg      = div_signed & A[31];
  assign b_neg      = div_signed & B[31];
  assign b_zero     = (B == 32'd0);
  assign a_mag      = a_neg ? (~A + 32'd1) : A;
  assign b_mag      = b_neg ? (~B + 32'd1) : B;
  assign dvsr       = b_zero ? 32'd1 : b_mag;
  assign uquo       = a_mag / dvsr;
  assign urem       = a_mag % dvsr;
  assign quo        = (a_neg ^ b_neg) ? (~uquo + 32'd1) : uquo;
  assign rem        = a_neg ? (~urem + 32'd1) : urem;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    phi_n    = phi;
    plo_n    = plo;
    pvalid_n = pvalid;
    hi_n     = hi_q;
    lo_n     = lo_q;
    case (state)
      IDLE: begin
        if (Start) begin
          case (MDUOp)
            OP_MULT: begin
              phi_n    = smul[63:32];
              plo_n    = smul[31:0];
              pvalid_n = 1'b1;
              cnt_n    = MULT_N;
              state_n  = RUN;
            end
            OP_MULTU: begin
              phi_n    = umul[63:32];
              plo_n    = umul[31:0];
              pvalid_n = 1'b1;
              cnt_n    = MULT_N;
              state_n  = RUN;
            end
            OP_DIV, OP_DIVU: begin
              // Divide by zero still runs the full busy period but never commits.
              phi_n    = rem;
              plo_n    = quo;
              pvalid_n = ~b_zero;
              cnt_n    = DIV_N;
              state_n  = RUN;
            end
            OP_MTHI: hi_n = A;
            OP_MTLO: lo_n = A;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_n = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          if (pvalid) begin
            hi_n = phi;
            lo_n = plo;
          end
          pvalid_n = 1'b0;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      cnt    <= '0;
      phi    <= '0;
      plo    <= '0;
      pvalid <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      phi    <= phi_n;
      plo    <= plo_n;
      pvalid <= pvalid_n;
      hi_q   <= hi_n;
      lo_q   <= lo_n;
    end
  end

  assign Busy = (state == RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit sitting beside the ALU in the execute stage. It consumes the two register-file read operands, the same ones feeding the ALU, and owns the architectural HI/LO registers, which feed the GRF write-data mux for MFHI/MFLO. Multiplies and divides are multi-cycle with a busy counter, and MTHI/MTLO are single-cycle writes. The controller stalls HI/LO reads and new MDU instructions while `Start | Busy` is high.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (must be ≥1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (must be ≥1)

Ports:
- clk  input  1  system clock, rising-edge
- Reset  input  1  asynchronous, active-high; clears all state
- Start  input  1  request strobe, qualified by MDUOp; one cycle per instruction
- MDUOp  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
- A  input  32  operand rs (dividend / multiplicand / MTHI-MTLO source)
- B  input  32  operand rt (divisor / multiplier)
- Busy  output  1  operation in progress
- HI  output  32  architectural HI register
- LO  output  32  architectural LO register

## Operation
- State: IDLE, RUN. Down-counter `cnt` (4+ bits, wide enough for max(MULT_CYCLES, DIV_CYCLES)). Pending result registers `pHI`/`pLO`. Flag `pValid`.
- IDLE, Start=1, MDUOp ∈ {MULT, MULTU, DIV, DIVU}:
  - compute the result from A/B sampled at that edge and load it into pHI/pLO
  - load cnt with MULT_CYCLES or DIV_CYCLES
  - enter RUN
- IDLE, Start=1, MTHI: HI ← A at the edge. MTLO: LO ← A. Busy stays 0. No-op codes: nothing changes.
- RUN: cnt decrements each edge. On the edge where cnt==1:
  - HI ← pHI and LO ← pLO, but only if pValid
  - return to IDLE
- Busy = (state == RUN), registered.
- Start while RUN: ignored entirely, MTHI/MTLO included. Operands are not re-sampled.
- MULT: signed 32×32 → 64. HI = product[63:32], LO = product[31:0]. MULTU: unsigned.
- DIV: signed, quotient truncated toward zero. LO = quotient; HI = remainder with the sign of the dividend.
- DIVU: unsigned.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Divide by zero (B == 0): full DIV_CYCLES busy period runs, pValid = 0, HI/LO keep their prior values.
- Reset (async, any time, including mid-RUN) forces:
  - HI = 0, LO = 0, Busy = 0, state IDLE, cnt = 0, pValid = 0
  - the in-flight result is discarded and never committed

## Timing
- Reset values: Busy = 0, HI = 0x00000000, LO = 0x00000000.
- Start high in cycle T (sampled at the end-of-T edge):
  - Busy = 1 in cycles T+1 … T+N, where N = MULT_CYCLES or DIV_CYCLES
  - HI/LO change at the end-of-(T+N) edge and are visible from T+N+1, the same cycle Busy first reads 0
- A new Start is accepted in cycle T+N+1 at the earliest. Back-to-back operations therefore have N+1 cycle spacing.
- MTHI/MTLO in cycle T: new value visible in T+1.
- Busy is 0 during cycle T itself. The controller's stall condition is Start_mdu | Busy, so an MFHI/MFLO in T+1 … T+N is stalled.
- HI/LO outputs are direct register outputs with no combinational path from A/B/Start.
- Reset asserted between edges takes effect immediately, without waiting for clk.

## Test plan
- Reset, then MTHI A=0x12345678 and next cycle MTLO A=0x9ABCDEF0 → HI=0x12345678 and LO=0x9ABCDEF0 one cycle after each; Busy never 1.
- MULT A=0xFFFFFFFE (−2), B=3 → Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU same operands → HI=0x00000002, LO=0xFFFFFFFA.
- DIV A=0xFFFFFFF9 (−7), B=2 → Busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=2 → LO=3, HI=1.
- MTHI and MULT issued during Busy → both ignored; the original result commits on schedule and HI is unchanged by the MTHI.
- DIV with B=0 after HI=0x11, LO=0x22 → Busy 10 cycles; HI=0x11, LO=0x22 afterwards. DIV 0x80000000 / −1 → LO=0x80000000, HI=0.
- Reset pulse at cycle 3 of a DIV → Busy=0 and HI=LO=0 immediately; no later commit; a new MULT issued after reset completes normally.
